mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter and sequencer for the 11-to-1 byte multiplexer. Up to 11 requesters share the single 8-bit mux output. The block picks one requester, drives the mux select, registers the selected byte, and presents it downstream on a valid/ready handshake. When the transfer completes, the winning requester receives a one-cycle acknowledge.

## Interface
Parameters:
- `N_SRC`, 11, number of requesters; fixed at 11 because the mux has 11 inputs.
- `DW`, 8, data width of the mux output.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  11  request bit per source; `req[i]` corresponds to mux input `xi`.
- `mux_y`  in  8  combinational output of the 11:1 mux.
- `sel`  out  4  registered select to the mux; only values 0x0–0xA are ever driven.
- `grant`  out  11  one-hot copy of the current owner; all zeros when idle.
- `ack`  out  11  one-cycle pulse on the winning bit when its byte is accepted downstream.
- `out_data`  out  8  registered byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine: IDLE → SEL → HOLD → IDLE.
- IDLE:
  - If `req != 0`, choose the winner.
  - Register `sel` = winner index and `grant` = one-hot winner, then go to SEL.
  - Otherwise stay in IDLE with `grant = 0`.
- SEL:
  - `sel` is now stable at the mux, so capture `out_data <= mux_y`.
  - Set `out_valid <= 1` and go to HOLD.
- HOLD:
  - `out_valid` and `out_data` stay constant while `out_ready = 0`.
  - On the first cycle with `out_valid && out_ready`:
    - Clear `out_valid` and pulse `ack[winner]` in the next cycle.
    - Set `ptr <= winner`, clear `grant`, and return to IDLE.
- Round-robin winner:
  - Search starts at `ptr+1` and wraps from 10 to 0.
  - The first index whose `req` bit is set wins.
  - `ptr` holds the last winner and is never 11–15.
- Once a winner is granted, the transaction runs to completion even if its `req` drops.
- Changes on `req` during SEL or HOLD are ignored until the next IDLE.
- `sel` holds its last value between transactions; it is only rewritten on a grant.
- Simultaneous requests resolve in a single cycle; losing requests keep waiting and need no re-assertion.
- A single persistent requester is granted back-to-back. With `out_ready` tied high, that is one transfer every 3 cycles.

## Timing
- Reset values:
  - `sel` = 0, `grant` = 0, `ack` = 0.
  - `out_data` = 0x00, `out_valid` = 0, `busy` = 0.
  - `ptr` = 10, so the first search starts at index 0.
  - State = IDLE.
- Reset is asynchronous: asserting `reset_n` low mid-transaction forces all of the above immediately. No `ack` is issued for the aborted transfer.
- Latency, with `req` sampled high in IDLE at edge N:
  - `sel` and `grant` valid after edge N.
  - `out_valid` high after edge N+1.
  - With `out_ready` = 1, the handshake completes at edge N+2.
  - `ack` is high for the cycle after edge N+2.
- `ack` is always exactly one cycle wide and coincides with the return to IDLE. A new grant can be issued in that same IDLE cycle.
- All outputs are registered; there are no combinational paths from `req`, `mux_y` or `out_ready` to any output.

## Configuration
- `MUX_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. The lowest set index of `req` always wins and `ptr` is unused. The search still ignores indices 11–15.
  - Undefined (default): round-robin as described under Operation.
  - Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset check: hold `reset_n` = 0 → every output at its reset value, with `busy` = 0.
- Single requester: `req` = 0x004, `mux_y` = 0x5A, `out_ready` = 1 →
  - `sel` = 2 after 1 cycle.
  - `out_data` = 0x5A with `out_valid` = 1 after 2 cycles.
  - `ack` = 0x004 for one cycle.
- Round-robin fairness: `req` = 0x7FF held, `out_ready` = 1 →
  - Grants are 0, 1, …, 10, 0 in order, one every 3 cycles.
  - `sel` never exceeds 0xA.
  - In the fixed-priority build, every grant is 0.
- Backpressure: `out_ready` = 0 for 5 cycles in HOLD →
  - `out_valid` stays 1 and `out_data` is stable.
  - No `ack` is issued.
  - The next grant follows only after `out_ready` = 1.
- Request drop: the granted `req` bit is deasserted in SEL → the transfer still completes and `ack` still pulses.
- Mid-transaction reset: assert `reset_n` low in HOLD → `out_valid`, `grant` and `busy` go to 0 immediately with no `ack`. After release, `ptr` = 10, so `req` = 0x401 grants index 0 first.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_arbiter
//  Purpose  : Arbiter/sequencer for an 11:1 byte mux. Picks one requester,
//             drives the mux select, registers the selected byte and hands
//             it downstream on a valid/ready handshake, then acks the winner.
//  Options  : MUX_ARB_FIXED_PRIO_EN - defined: lowest set request index wins;
//             undefined (default): round-robin starting after the last winner.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int N_SRC = 11,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] req,
  input  logic [DW-1:0]    mux_y,
  output logic [3:0]       sel,
  output logic [N_SRC-1:0] grant,
  output logic [N_SRC-1:0] ack,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [N_SRC-1:0] ack_q, ack_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             win_found;
  logic [3:0]       win_idx;

  // Winner search: scan in reverse preference order so the most preferred
  // set request is the last one written and therefore wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = 4'd0;
    idx       = 0;
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx = i;
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx[3:0];
      end
    end
`else
    for (int k = N_SRC; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % N_SRC;
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx[3:0];
      end
    end
`endif
  end

  // Next-state and next-output logic for IDLE -> SEL -> HOLD -> IDLE.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    ack_d       = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          sel_d   = win_idx;
          grant_d = {{(N_SRC-1){1'b0}}, 1'b1} << win_idx;
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        // sel has been stable at the mux for a full cycle; capture its output.
        out_data_d  = mux_y;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = grant_q;
          ptr_d       = sel_q;
          grant_d     = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; ptr resets to 10 so the first search starts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 4'd0;
      ptr_q       <= 4'd10;
      grant_q     <= '0;
      ack_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign ack       = ack_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_rr_arbiter
//  Purpose  : Self-checking bench for mux_rr_arbiter using a transaction-level
//             reference model of the arbitration rule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

  logic        clk;
  logic        reset_n;
  logic [10:0] req;
  logic [7:0]  mux_y;
  logic [3:0]  sel;
  logic [10:0] grant;
  logic [10:0] ack;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks;
  int n_fail;
  int ptr_m;

  mux_rr_arbiter #(.N_SRC(11), .DW(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .mux_y     (mux_y),
    .sel       (sel),
    .grant     (grant),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the index that should win given last winner p and requests r.
  function automatic int pick(input int p, input logic [10:0] r);
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 11; i++)
      if (r[i]) return i;
`else
    for (int k = 1; k <= 11; k++)
      if (r[(p + k) % 11]) return (p + k) % 11;
`endif
    return -1;
  endfunction

  function automatic logic [10:0] onehot(input int i);
    logic [10:0] v;
    v = 11'd1;
    return v << i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer from IDLE; delay = cycles of backpressure in HOLD.
  task automatic run_txn(input logic [10:0] r, input logic [7:0] d,
                         input int delay, input bit drop);
    int w;
    w = pick(ptr_m, r);
    req = r; mux_y = d; out_ready = 1'b0;
    step();
    n_checks++;
    if (grant !== onehot(w) || sel !== 4'(w)) begin
      n_fail++; $display("FAIL txn_grant: grant=%h sel=%0d want grant=%h sel=%0d", grant, sel, onehot(w), w);
    end
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || ack !== 11'd0) begin
      n_fail++; $display("FAIL txn_sel_state: busy=%b valid=%b ack=%h want 1 0 000", busy, out_valid, ack);
    end
    if (drop) req = r & ~onehot(w);
    else      req = r ^ 11'h7FF;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== d) begin
      n_fail++; $display("FAIL txn_capture: valid=%b data=%h want 1 %h", out_valid, out_data, d);
    end
    for (int c = 0; c < delay; c++) begin
      mux_y = 8'($urandom);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== d || ack !== 11'd0 || grant !== onehot(w)) begin
        n_fail++; $display("FAIL txn_hold: valid=%b data=%h ack=%h grant=%h want 1 %h 000 %h", out_valid, out_data, ack, grant, d, onehot(w));
      end
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (ack !== onehot(w) || out_valid !== 1'b0 || grant !== 11'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL txn_ack: ack=%h valid=%b grant=%h busy=%b want %h 0 000 0", ack, out_valid, grant, busy, onehot(w));
    end
    ptr_m = w;
    req = 11'd0; out_ready = 1'b0;
    step();
    n_checks++;
    if (ack !== 11'd0 || grant !== 11'd0 || busy !== 1'b0 || sel !== 4'(w)) begin
      n_fail++; $display("FAIL txn_after: ack=%h grant=%h busy=%b sel=%0d want 000 000 0 %0d", ack, grant, busy, sel, w);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 11'h7FF; mux_y = 8'hFF; out_ready = 1'b1;
    #2;
    n_checks++;
    if (sel !== 4'd0 || grant !== 11'd0 || ack !== 11'd0 || out_data !== 8'h00 ||
        out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset: sel=%0d grant=%h ack=%h data=%h valid=%b busy=%b want all 0",
                         sel, grant, ack, out_data, out_valid, busy);
    end
    step();
    req = 11'd0; out_ready = 1'b0;
    reset_n = 1'b1;
    ptr_m = 10;
    step();
  endtask

  // Persistent full request with ready high: one grant every 3 cycles.
  task automatic test_round_robin();
    int exp;
    req = 11'h7FF; out_ready = 1'b1; mux_y = 8'hC3;
    exp = pick(ptr_m, req);
    for (int t = 0; t < 36; t++) begin
      step();
      if (t % 3 == 0) begin
        n_checks++;
        if (grant !== onehot(exp) || sel !== 4'(exp) || sel > 4'd10) begin
          n_fail++; $display("FAIL rr_grant: t=%0d grant=%h sel=%0d want %h %0d", t, grant, sel, onehot(exp), exp);
        end
      end else if (t % 3 == 2) begin
        n_checks++;
        if (ack !== onehot(exp) || out_valid !== 1'b0) begin
          n_fail++; $display("FAIL rr_ack: t=%0d ack=%h valid=%b want %h 0", t, ack, out_valid, onehot(exp));
        end
        ptr_m = exp;
        exp = pick(ptr_m, req);
      end
    end
    req = 11'd0; out_ready = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || grant !== 11'd0) begin
      n_fail++; $display("FAIL rr_idle: busy=%b grant=%h want 0 000", busy, grant);
    end
  endtask

  task automatic test_single();
    run_txn(11'h004, 8'h5A, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_txn(11'h090, 8'hA5, 5, 1'b0);
  endtask

  task automatic test_req_drop();
    run_txn(11'h200, 8'h3C, 1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++)
      run_txn(11'($urandom_range(1, 2047)), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
  endtask

  task automatic test_mid_reset();
    req = 11'h002; mux_y = 8'h77; out_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: valid=%b busy=%b want 1 1", out_valid, busy);
    end
    out_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 11'd0 || busy !== 1'b0 || ack !== 11'd0 || sel !== 4'd0) begin
      n_fail++; $display("FAIL midrst_async: valid=%b grant=%h busy=%b ack=%h sel=%0d want 0 000 0 000 0",
                         out_valid, grant, busy, ack, sel);
    end
    step();
    n_checks++;
    if (ack !== 11'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_noack: ack=%h valid=%b want 000 0", ack, out_valid);
    end
    req = 11'd0; out_ready = 1'b0;
    reset_n = 1'b1;
    ptr_m = 10;
    step();
    n_checks++;
    if (pick(ptr_m, 11'h401) != 0) begin
      n_fail++; $display("FAIL midrst_model: winner=%0d want 0", pick(ptr_m, 11'h401));
    end
    run_txn(11'h401, 8'hE1, 0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ptr_m    = 10;
    reset_n  = 1'b0;
    req      = 11'd0;
    mux_y    = 8'd0;
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_req_drop();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
